// File: rtl/ysyx_22041211_pkg.sv
// Shared definitions for the NPC decode stage: opcodes, instruction-type
// codes, system-instruction words and encodings, and the decode FSM states.
package ysyx_22041211_pkg;

   // RV32I major opcodes (inst[6:0])
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // out_type encodings
   localparam logic [2:0] TYPE_I   = 3'b000;
   localparam logic [2:0] TYPE_N   = 3'b001;
   localparam logic [2:0] TYPE_U   = 3'b010;
   localparam logic [2:0] TYPE_R   = 3'b011;
   localparam logic [2:0] TYPE_S   = 3'b100;
   localparam logic [2:0] TYPE_J   = 3'b101;
   localparam logic [2:0] TYPE_B   = 3'b110;
   localparam logic [2:0] TYPE_INV = 3'b111;

   // Complete instruction words of the two recognised system instructions
   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   // out_sys encodings
   localparam logic [1:0] SYS_NONE   = 2'b00;
   localparam logic [1:0] SYS_ECALL  = 2'b01;
   localparam logic [1:0] SYS_EBREAK = 2'b10;

   // Decode-stage operating state; HALT is sticky until reset
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   // Classify a full instruction word as ecall, ebreak or neither
   function automatic logic [1:0] sys_of(input logic [31:0] inst);
      logic [1:0] sys;
      sys = SYS_NONE;
      if (inst == INST_ECALL) begin
         sys = SYS_ECALL;
      end else if (inst == INST_EBREAK) begin
         sys = SYS_EBREAK;
      end
      return sys;
   endfunction

endpackage

// File: rtl/ysyx_22041211_imm_gen.sv
// Combinational instruction classifier and immediate generator.
// Maps a 32-bit instruction to its format type, its sign-extended
// immediate (DATA_LEN wide) and an illegal flag.
module ysyx_22041211_imm_gen
   import ysyx_22041211_pkg::*;
#(
   parameter int DATA_LEN = 32
) (
   input  logic [31:0]         inst,
   output logic [2:0]          kind,
   output logic [DATA_LEN-1:0] imm,
   output logic                illegal
);

   logic signed [11:0] imm_i;
   logic signed [11:0] imm_s;
   logic signed [12:0] imm_b;
   logic signed [20:0] imm_j;
   logic signed [31:0] imm_u;

   assign imm_i = inst[31:20];
   assign imm_s = {inst[31:25], inst[11:7]};
   assign imm_b = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};

   // Pick the format from the opcode; signed casts sign-extend to DATA_LEN
   always_comb begin
      kind    = TYPE_INV;
      imm     = '0;
      illegal = 1'b0;
      case (inst[6:0])
         OP_IMM, OP_LOAD, OP_JALR: begin
            kind = TYPE_I;
            imm  = DATA_LEN'(imm_i);
         end
         OP_SYSTEM: begin
            kind    = TYPE_N;
            illegal = (sys_of(inst) == SYS_NONE);
         end
         OP_LUI, OP_AUIPC: begin
            kind = TYPE_U;
            imm  = DATA_LEN'(imm_u);
         end
         OP_REG: begin
            kind = TYPE_R;
         end
         OP_STORE: begin
            kind = TYPE_S;
            imm  = DATA_LEN'(imm_s);
         end
         OP_JAL: begin
            kind = TYPE_J;
            imm  = DATA_LEN'(imm_j);
         end
         OP_BRANCH: begin
            kind = TYPE_B;
            imm  = DATA_LEN'(imm_b);
         end
         default: begin
            kind    = TYPE_INV;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/ysyx_22041211_idu.sv
// Registered instruction-decode stage of the NPC core.
// Decodes each accepted instruction into a registered output beat, counts
// output handshakes and halts after an ebreak has been handed downstream.
// Build option YSYX_22041211_IDU_SKID_EN: two-entry skid buffer with a
// registered in_ready; otherwise a single output register whose in_ready
// depends combinationally on out_ready.
module ysyx_22041211_idu
   import ysyx_22041211_pkg::*;
#(
   parameter int DATA_LEN = 32,
   parameter int ADDR_LEN = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_inst,
   input  logic [ADDR_LEN-1:0] in_pc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ADDR_LEN-1:0] out_pc,
   output logic [2:0]          out_type,
   output logic [DATA_LEN-1:0] out_imm,
   output logic [4:0]          out_rs1,
   output logic [4:0]          out_rs2,
   output logic [4:0]          out_rd,
   output logic [2:0]          out_funct3,
   output logic [6:0]          out_funct7,
   output logic [1:0]          out_sys,
   output logic                out_illegal,
   output logic                halt,
   output logic [31:0]         dec_cnt
);

   typedef struct packed {
      logic [ADDR_LEN-1:0] pc;
      logic [2:0]          kind;
      logic [DATA_LEN-1:0] imm;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [4:0]          rd;
      logic [2:0]          funct3;
      logic [6:0]          funct7;
      logic [1:0]          sys;
      logic                illegal;
   } beat_t;

   state_t state_q, state_d;

   beat_t in_beat;
   beat_t main_q, main_d;
   logic  main_valid_q, main_valid_d;

`ifdef YSYX_22041211_IDU_SKID_EN
   beat_t skid_q, skid_d;
   logic  skid_valid_q, skid_valid_d;
   logic  ready_q, ready_d;
`endif

   logic [2:0]          dec_kind;
   logic [DATA_LEN-1:0] dec_imm;
   logic                dec_illegal;

   logic in_fire;
   logic out_fire;
   logic halt_fire;

   ysyx_22041211_imm_gen #(
      .DATA_LEN (DATA_LEN)
   ) u_imm_gen (
      .inst    (in_inst),
      .kind    (dec_kind),
      .imm     (dec_imm),
      .illegal (dec_illegal)
   );

   assign in_beat.pc      = in_pc;
   assign in_beat.kind    = dec_kind;
   assign in_beat.imm     = dec_imm;
   assign in_beat.rs1     = in_inst[19:15];
   assign in_beat.rs2     = in_inst[24:20];
   assign in_beat.rd      = in_inst[11:7];
   assign in_beat.funct3  = in_inst[14:12];
   assign in_beat.funct7  = in_inst[31:25];
   assign in_beat.sys     = sys_of(in_inst);
   assign in_beat.illegal = dec_illegal;

`ifdef YSYX_22041211_IDU_SKID_EN
   assign in_ready = rst_n && ready_q;
`else
   assign in_ready = rst_n && (state_q == ST_RUN) && (!main_valid_q || out_ready);
`endif

   assign out_valid = main_valid_q;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = main_valid_q && out_ready;
   assign halt_fire = out_fire && (main_q.sys == SYS_EBREAK);

   assign out_pc      = main_q.pc;
   assign out_type    = main_q.kind;
   assign out_imm     = main_q.imm;
   assign out_rs1     = main_q.rs1;
   assign out_rs2     = main_q.rs2;
   assign out_rd      = main_q.rd;
   assign out_funct3  = main_q.funct3;
   assign out_funct7  = main_q.funct7;
   assign out_sys     = main_q.sys;
   assign out_illegal = main_q.illegal;
   assign halt        = (state_q == ST_HALT);

   // Next FSM state: RUN falls into HALT once an ebreak beat retires
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:  if (halt_fire) state_d = ST_HALT;
         ST_HALT: state_d = ST_HALT;
      endcase
   end

   // Next buffer contents; entering HALT discards everything still held
   always_comb begin
      main_valid_d = main_valid_q;
      main_d       = main_q;
`ifdef YSYX_22041211_IDU_SKID_EN
      skid_valid_d = skid_valid_q;
      skid_d       = skid_q;
      if (!main_valid_q || out_fire) begin
         if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_d       = skid_q;
            skid_valid_d = in_fire;
            if (in_fire) skid_d = in_beat;
         end else begin
            main_valid_d = in_fire;
            if (in_fire) main_d = in_beat;
         end
      end else if (in_fire) begin
         skid_valid_d = 1'b1;
         skid_d       = in_beat;
      end
      if (state_d == ST_HALT) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end
      ready_d = (state_d == ST_RUN) && !skid_valid_d;
`else
      if (in_fire) begin
         main_valid_d = 1'b1;
         main_d       = in_beat;
      end else if (out_fire) begin
         main_valid_d = 1'b0;
      end
      if (state_d == ST_HALT) begin
         main_valid_d = 1'b0;
      end
`endif
   end

   // State, buffer and handshake counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_RUN;
         main_valid_q <= 1'b0;
         main_q       <= '0;
         dec_cnt      <= '0;
`ifdef YSYX_22041211_IDU_SKID_EN
         skid_valid_q <= 1'b0;
         skid_q       <= '0;
         ready_q      <= 1'b1;
`endif
      end else begin
         state_q      <= state_d;
         main_valid_q <= main_valid_d;
         main_q       <= main_d;
         if (out_fire) dec_cnt <= dec_cnt + 32'd1;
`ifdef YSYX_22041211_IDU_SKID_EN
         skid_valid_q <= skid_valid_d;
         skid_q       <= skid_d;
         ready_q      <= ready_d;
`endif
      end
   end

endmodule
